// File: rtl/cordic_fixed_to_float_if.sv
// Start/done handshake bundle between the CORDIC core side and the fixed-to-float normaliser.
// The master drives the request and stall control; the slave returns the float and its done pulse.
interface cordic_fixed_to_float_if #(
  parameter int WIDTH = 23
);
  logic             clk_en;
  logic             start;
  logic [WIDTH-1:0] fixedPoint_in;
  logic [31:0]      floatingPoint_result;
  logic             done;

  modport master (
    output clk_en,
    output start,
    output fixedPoint_in,
    input  floatingPoint_result,
    input  done
  );

  modport slave (
    input  clk_en,
    input  start,
    input  fixedPoint_in,
    output floatingPoint_result,
    output done
  );
endinterface

// File: rtl/cordic_fixed_to_float.sv
// Iterative signed Q(WIDTH-FRAC).FRAC to IEEE-754 single converter: one normalising left shift
// per enabled cycle, result registered and held until the next completion.
module cordic_fixed_to_float #(
  parameter int WIDTH = 23,
  parameter int FRAC  = 21
) (
  input  logic                    clk,
  input  logic                    reset,
  cordic_fixed_to_float_if.slave  bus
);

  typedef enum logic {
    IDLE,
    NORM
  } state_t;

  // Biased exponent of the value when the input MSB position (WIDTH-1) is the leading one.
  localparam logic [7:0] EXP_INIT = 8'(127 + (WIDTH - 1) - FRAC);

  state_t           state_q;
  logic             sign_q;
  logic [WIDTH-1:0] mag_q;
  logic [7:0]       exp_q;
  logic [31:0]      result_q;
  logic             done_q;

  logic [WIDTH-1:0] mag_d;

  // Hidden bit sits at mag[WIDTH-1]; the bits below it become the top of the 23-bit fraction.
  function automatic logic [22:0] left_align(input logic [WIDTH-1:0] m);
    logic [23:0] wide;
    wide = 24'(m) << (24 - WIDTH);
    return wide[22:0];
  endfunction

  // Negating the most negative input wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
  always_comb begin
    mag_d = bus.fixedPoint_in;
    if (bus.fixedPoint_in[WIDTH-1]) begin
      mag_d = ~bus.fixedPoint_in + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      exp_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else if (bus.clk_en) begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            sign_q  <= bus.fixedPoint_in[WIDTH-1];
            mag_q   <= mag_d;
            exp_q   <= EXP_INIT;
            state_q <= NORM;
          end
        end
        NORM: begin
          if (mag_q == '0) begin
            result_q <= 32'h0000_0000;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end else if (mag_q[WIDTH-1]) begin
            result_q <= {sign_q, exp_q, left_align(mag_q)};
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end else begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.floatingPoint_result = result_q;
  assign bus.done                 = done_q;

endmodule

// File: tb/tb_cordic_fixed_to_float.sv
// Bench for cordic_fixed_to_float: directed conversions with literal expectations, plus a
// value/latency model compared against the DUT on every falling edge.
module tb_cordic_fixed_to_float;
  localparam int WIDTH = 23;
  localparam int FRAC  = 21;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int checks = 0;
  int errors = 0;

  cordic_fixed_to_float_if #(.WIDTH(WIDTH)) ifc ();

  cordic_fixed_to_float #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  // Float value of the input computed from its numeric value: leading-one position gives the exponent.
  function automatic logic [31:0] f2f(input logic [WIDTH-1:0] x);
    longint v, a;
    int msb;
    logic [31:0] r;
    v = longint'($signed(x));
    a = (v < 0) ? -v : v;
    if (a == 0) return 32'h0;
    msb = 0;
    for (int i = 0; i < WIDTH; i++) if (a[i]) msb = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + msb - FRAC);
    r[22:0]  = 23'((a << (23 - msb)) & 64'h7FFFFF);
    return r;
  endfunction

  function automatic int lat(input logic [WIDTH-1:0] x);
    longint v, a;
    int msb;
    v = longint'($signed(x));
    a = (v < 0) ? -v : v;
    if (a == 0) return 1;
    msb = 0;
    for (int i = 0; i < WIDTH; i++) if (a[i]) msb = i;
    return (WIDTH - 1 - msb) + 1;
  endfunction

  // Model: busy countdown of enabled cycles, then a one-cycle done with the precomputed value.
  logic        m_busy, m_done;
  int          m_rem;
  logic [31:0] m_res, m_pend;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_rem  <= 0;
      m_res  <= 32'h0;
      m_pend <= 32'h0;
    end else if (ifc.clk_en) begin
      if (!m_busy) begin
        m_done <= 1'b0;
        if (ifc.start) begin
          m_busy <= 1'b1;
          m_rem  <= lat(ifc.fixedPoint_in);
          m_pend <= f2f(ifc.fixedPoint_in);
        end
      end else if (m_rem == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_res  <= m_pend;
      end else begin
        m_rem <= m_rem - 1;
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (ifc.done !== m_done || ifc.floatingPoint_result !== m_res) begin
      errors++;
      $display("FAIL model_compare t=%0t actual done=%b res=%h required done=%b res=%h",
               $time, ifc.done, ifc.floatingPoint_result, m_done, m_res);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the accepting rising edge.
  task automatic kick(input logic [WIDTH-1:0] x);
    ifc.start         = 1'b1;
    ifc.fixedPoint_in = x;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic [31:0] res, input int cyc);
    int n;
    n = 0;
    while (!ifc.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_seen"}, 32'(ifc.done), 32'd1);
    chk({name, "_latency"}, 32'(n), 32'(cyc));
    chk({name, "_result"}, ifc.floatingPoint_result, res);
  endtask

  task automatic convert(input string name, input logic [WIDTH-1:0] x,
                         input logic [31:0] res, input int cyc);
    kick(x);
    wait_done(name, res, cyc);
    @(negedge clk);
    chk({name, "_pulse_clear"}, 32'(ifc.done), 32'd0);
    chk({name, "_result_held"}, ifc.floatingPoint_result, res);
  endtask

  initial begin
    int dones;
    ifc.clk_en        = 1'b1;
    ifc.start         = 1'b0;
    ifc.fixedPoint_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_done", 32'(ifc.done), 32'd0);
    chk("reset_result", ifc.floatingPoint_result, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Pin the model against hand-computed values.
    chk("model_half", f2f(23'h114BC6), 32'h3F0A5E30);
    chk("model_min", f2f(23'h000001), 32'h35000000);
    chk("model_lat_min", 32'(lat(23'h000001)), 32'd23);

    convert("one",      23'h200000, 32'h3F800000, 2);
    convert("c0p5405",  23'h114BC6, 32'h3F0A5E30, 3);
    convert("neg_one",  23'h600000, 32'hBF800000, 2);
    convert("neg_two",  23'h400000, 32'hC0000000, 1);
    convert("zero",     23'h000000, 32'h00000000, 1);
    convert("lsb",      23'h000001, 32'h35000000, 23);
    convert("max_pos",  23'h3FFFFF, 32'h3FFFFFFC, 2);
    convert("neg_lsb",  23'h7FFFFF, 32'hB5000000, 23);

    // Stall five cycles mid-normalisation.
    kick(23'h114BC6);
    ifc.clk_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("stall_no_done", 32'(ifc.done), 32'd0);
    chk("stall_result_held", ifc.floatingPoint_result, 32'hB5000000);
    ifc.clk_en = 1'b1;
    wait_done("stall", 32'h3F0A5E30, 3);
    @(negedge clk);

    // Start while busy must be ignored.
    kick(23'h000001);
    ifc.start         = 1'b1;
    ifc.fixedPoint_in = 23'h200000;
    @(negedge clk);
    ifc.start = 1'b0;
    wait_done("busy_start", 32'h35000000, 22);

    // Back-to-back start on the done cycle.
    kick(23'h400000);
    wait_done("b2b_first", 32'hC0000000, 1);
    kick(23'h114BC6);
    wait_done("b2b_second", 32'h3F0A5E30, 3);
    @(negedge clk);

    // Asynchronous reset between edges, mid-normalisation.
    kick(23'h000001);
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("areset_done", 32'(ifc.done), 32'd0);
    chk("areset_result", ifc.floatingPoint_result, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (ifc.done) dones++;
    end
    chk("areset_no_done", 32'(dones), 32'd0);
    convert("after_reset", 23'h600000, 32'hBF800000, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
